// File: rtl/textlcd_pkg.sv
// rtl/textlcd_pkg.sv - shared state encoding and command constants for the text LCD bus scheduler
package textlcd_pkg;

  localparam logic [2:0] ST_PWRUP = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_EHIGH = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_IDLE  = 3'd5;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;

  localparam int INIT_LEN = 4;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = CMD_FUNC_SET;
      2'd1:    init_cmd = CMD_DISP_ON;
      2'd2:    init_cmd = CMD_ENTRY;
      default: init_cmd = CMD_CLEAR;
    endcase
  endfunction

  // Clear and home are the only writes the controller needs the long busy wait for.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; ptr_i names the client that wins a tie
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       enable_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o,
  output logic       ptr_next_o
);

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      if (req_i == 2'b11) grant_o = ptr_i ? 2'b10 : 2'b01;
      else                grant_o = req_i;
    end
    ptr_next_o = ptr_i;
    if (grant_o[0])      ptr_next_o = 1'b1;
    else if (grant_o[1]) ptr_next_o = 1'b0;
  end

endmodule

// File: rtl/textlcd_bus_sched.sv
// rtl/textlcd_bus_sched.sv - HD44780 bus sequencer: power-up init, then round-robin client writes with timed E strobe
module textlcd_bus_sched
  import textlcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC  = 100,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned E_HIGH_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned CMD_WAIT   = 40,
  parameter int unsigned CLR_WAIT   = 200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       rs0,
  input  logic [7:0] data0,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic [1:0] ack,
  output logic       busy,
  output logic       init_done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic        in_init_q, in_init_d;
  logic [1:0]  idx_q, idx_d;
  logic        src_rs_q, src_rs_d;
  logic [7:0]  src_data_q, src_data_d;
  logic        gnt_q, gnt_d;
  logic [1:0]  ack_q, ack_d;
  logic        init_done_q, init_done_d;
  logic        busy_q, e_q, rs_q;
  logic [7:0]  data_q;

  logic [1:0]  grant;
  logic        ptr_next;
  logic [15:0] wait_last;

  // No grant in the ack cycle, so back-to-back clients always see one idle cycle.
  rr_arb2 u_arb (
    .req_i      (req),
    .enable_i   ((state_q == ST_IDLE) && (ack_q == 2'b00)),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .ptr_next_o (ptr_next)
  );

  assign wait_last = is_slow_cmd(src_rs_q, src_data_q) ? 16'(CLR_WAIT - 1) : 16'(CMD_WAIT - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    ptr_d       = ptr_q;
    in_init_d   = in_init_q;
    idx_d       = idx_q;
    src_rs_d    = src_rs_q;
    src_data_d  = src_data_q;
    gnt_d       = gnt_q;
    ack_d       = 2'b00;
    init_done_d = init_done_q;
    case (state_q)
      ST_PWRUP: if (cnt_q == 16'(PWRUP_CYC - 1)) begin
        state_d    = ST_SETUP;
        cnt_d      = '0;
        in_init_d  = 1'b1;
        idx_d      = 2'd0;
        src_rs_d   = 1'b0;
        src_data_d = init_cmd(2'd0);
      end
      // One extra SETUP cycle loads the bus register; the pins then sit SETUP_CYC cycles before E.
      ST_SETUP: if (cnt_q == 16'(SETUP_CYC)) begin
        state_d = ST_EHIGH;
        cnt_d   = '0;
      end
      ST_EHIGH: if (cnt_q == 16'(E_HIGH_CYC - 1)) begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
      ST_HOLD: if (cnt_q == 16'(HOLD_CYC - 1)) begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: if (cnt_q == wait_last) begin
        cnt_d = '0;
        if (!in_init_q) begin
          state_d = ST_IDLE;
          ack_d   = gnt_q ? 2'b10 : 2'b01;
        end else if (idx_q == 2'(INIT_LEN - 1)) begin
          state_d     = ST_IDLE;
          in_init_d   = 1'b0;
          init_done_d = 1'b1;
        end else begin
          state_d    = ST_SETUP;
          idx_d      = idx_q + 2'd1;
          src_data_d = init_cmd(idx_q + 2'd1);
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (grant != 2'b00) begin
          state_d    = ST_SETUP;
          ptr_d      = ptr_next;
          gnt_d      = grant[1];
          src_rs_d   = grant[1] ? rs1 : rs0;
          src_data_d = grant[1] ? data1 : data0;
        end
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      in_init_q   <= 1'b1;
      idx_q       <= 2'd0;
      src_rs_q    <= 1'b0;
      src_data_q  <= 8'h00;
      gnt_q       <= 1'b0;
      ack_q       <= 2'b00;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      in_init_q   <= in_init_d;
      idx_q       <= idx_d;
      src_rs_q    <= src_rs_d;
      src_data_q  <= src_data_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      init_done_q <= init_done_d;
      busy_q      <= (state_d != ST_IDLE);
      e_q         <= (state_d == ST_EHIGH);
      if (state_q == ST_SETUP) begin
        rs_q   <= src_rs_q;
        data_q <= src_data_q;
      end
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign LCD_E     = e_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_DATA  = data_q;

endmodule

// File: tb/tb_textlcd_bus_sched.sv
// tb/tb_textlcd_bus_sched.sv - self-checking bench for textlcd_bus_sched
module tb_textlcd_bus_sched;

  localparam int PWRUP_CYC  = 100;
  localparam int SETUP_CYC  = 2;
  localparam int E_HIGH_CYC = 4;
  localparam int HOLD_CYC   = 2;
  localparam int CMD_WAIT   = 40;
  localparam int CLR_WAIT   = 200;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] req = 2'b00;
  logic       rs0 = 1'b0, rs1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic [1:0] ack;
  logic       busy, init_done, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  textlcd_bus_sched #(
    .PWRUP_CYC(PWRUP_CYC), .SETUP_CYC(SETUP_CYC), .E_HIGH_CYC(E_HIGH_CYC),
    .HOLD_CYC(HOLD_CYC), .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .rs0(rs0), .data0(data0), .rs1(rs1), .data1(data1),
    .ack(ack), .busy(busy), .init_done(init_done),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       rw;
    int         setup;
    int         width;
    int         rise;
    int         fall;
  } pulse_t;

  typedef struct {
    logic [1:0] mask;
    logic       r0;
    logic [7:0] d0;
    logic       r1;
    logic [7:0] d1;
    logic       first;
  } vec_t;

  pulse_t     pulses[$];
  pulse_t     cur;
  int         checks = 0, failures = 0, cyc = 0, ack_count = 0, rel_cyc = 0;
  int         width = 0, stable = 0;
  logic       e_prev = 1'b0;
  logic [1:0] ack_prev = 2'b00;
  logic [8:0] bus_prev = 9'h000;
  logic       ptr_m = 1'b0;
  logic [7:0] init_exp [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input logic cond, input int act);
    checks++;
    if (!cond) begin
      failures++;
      $display("FAIL %s: got %0d outside allowed range", name, act);
    end
  endtask

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? CLR_WAIT : CMD_WAIT;
  endfunction

  function automatic int lat_of(input logic rs, input logic [7:0] d);
    return SETUP_CYC + E_HIGH_CYC + HOLD_CYC + wait_of(rs, d) + 1;
  endfunction

  // Bus monitor, sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (ack_prev != 2'b00) chk("ack_single_cycle", int'(ack), 0);
    if (ack != 2'b00) ack_count++;
    ack_prev = ack;
    if (LCD_E && !e_prev) begin
      cur.rs = LCD_RS; cur.data = LCD_DATA; cur.rw = LCD_RW;
      cur.setup = stable; cur.rise = cyc; width = 0;
    end
    if (LCD_E) width++;
    if (!LCD_E && e_prev) begin
      cur.width = width; cur.fall = cyc;
      pulses.push_back(cur);
    end
    if (!LCD_E && {LCD_RS, LCD_DATA} == bus_prev) stable++;
    else stable = LCD_E ? 0 : 1;
    bus_prev = {LCD_RS, LCD_DATA};
    e_prev = LCD_E;
  end

  task automatic do_reset(input int ncyc);
    resetn = 1'b0;
    req = 2'b00;
    repeat (ncyc) @(negedge clk);
    chk("rst_lcd_e", int'(LCD_E), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_bus", int'({LCD_RS, LCD_RW, LCD_DATA}), 0);
    pulses.delete();
    ptr_m = 1'b0;
    resetn = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic check_init(input string tag);
    int n, gap;
    n = 0;
    while (!init_done && n < 2000) begin @(negedge clk); n++; end
    chk({tag, "_init_done"}, int'(init_done), 1);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_init_pulses"}, pulses.size(), 4);
    if (pulses.size() >= 4) begin
      gap = pulses[0].rise - rel_cyc;
      chk_true({tag, "_pwrup_len"}, gap >= PWRUP_CYC + SETUP_CYC && gap <= PWRUP_CYC + SETUP_CYC + 2, gap);
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_init_data"}, int'(pulses[i].data), int'(init_exp[i]));
        chk({tag, "_init_rs_rw"}, int'({pulses[i].rs, pulses[i].rw}), 0);
        chk({tag, "_init_e_width"}, pulses[i].width, E_HIGH_CYC);
        chk_true({tag, "_init_setup"}, pulses[i].setup >= SETUP_CYC, pulses[i].setup);
        if (i < 3) begin
          gap = pulses[i+1].rise - pulses[i].fall;
          chk_true({tag, "_init_short_gap"},
                   gap >= HOLD_CYC + CMD_WAIT + SETUP_CYC && gap < HOLD_CYC + CLR_WAIT, gap);
        end
      end
      chk({tag, "_clear_wait"}, cyc - pulses[3].fall, HOLD_CYC + CLR_WAIT);
    end
  endtask

  task automatic run_round(input vec_t v, input string tag);
    int n, p0, t0, k, nexp;
    int ack_at[2];
    int who[2];
    logic       prs;
    logic [7:0] pd;
    n = 0;
    while ((busy || ack != 2'b00) && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_idle_before"}, int'(busy), 0);
    p0 = pulses.size();
    t0 = cyc;
    rs0 = v.r0; data0 = v.d0; rs1 = v.r1; data1 = v.d1; req = v.mask;
    nexp = (v.mask == 2'b11) ? 2 : 1;
    k = 0; n = 0;
    while (req != 2'b00 && n < 3000) begin
      @(negedge clk); n++;
      if (ack != 2'b00) begin
        chk_true({tag, "_ack_owner"}, $onehot(ack) && ((ack & req) == ack), int'(ack));
        if (k < 2) begin who[k] = ack[1] ? 1 : 0; ack_at[k] = cyc; end
        k++;
        req = req & ~ack;
      end
    end
    req = 2'b00;
    chk({tag, "_ack_count"}, k, nexp);
    chk({tag, "_pulse_count"}, pulses.size() - p0, nexp);
    if (k == nexp && pulses.size() - p0 == nexp) begin
      for (int j = 0; j < nexp; j++) begin
        chk({tag, "_order"}, who[j], (j == 0) ? int'(v.first) : int'(!v.first));
        prs = who[j] ? v.r1 : v.r0;
        pd  = who[j] ? v.d1 : v.d0;
        chk({tag, "_pulse_bus"}, int'({pulses[p0+j].rs, pulses[p0+j].rw, pulses[p0+j].data}),
            int'({prs, 1'b0, pd}));
        chk({tag, "_e_width"}, pulses[p0+j].width, E_HIGH_CYC);
        chk({tag, "_post_wait"}, ack_at[j] - pulses[p0+j].fall, HOLD_CYC + wait_of(prs, pd));
        if (j == 0) chk({tag, "_latency"}, ack_at[0] - (t0 + 1), lat_of(prs, pd));
        else        chk({tag, "_skip_latency"}, ack_at[1] - (ack_at[0] + 2), lat_of(prs, pd));
      end
    end
    ptr_m = (v.mask == 2'b11) ? v.first : !v.mask[1];
  endtask

  initial begin
    vec_t vecs[6];
    vec_t rv;
    int n, a0, rel;
    init_exp[0] = 8'h38; init_exp[1] = 8'h0C; init_exp[2] = 8'h06; init_exp[3] = 8'h01;
    vecs[0] = '{mask: 2'b10, r0: 1'b1, d0: 8'h00, r1: 1'b0, d1: 8'h01, first: 1'b1};
    vecs[1] = '{mask: 2'b11, r0: 1'b1, d0: 8'h42, r1: 1'b1, d1: 8'h43, first: 1'b0};
    vecs[2] = '{mask: 2'b11, r0: 1'b0, d0: 8'h80, r1: 1'b1, d1: 8'hFF, first: 1'b0};
    vecs[3] = '{mask: 2'b01, r0: 1'b1, d0: 8'h41, r1: 1'b0, d1: 8'h00, first: 1'b0};
    vecs[4] = '{mask: 2'b11, r0: 1'b0, d0: 8'h02, r1: 1'b1, d1: 8'h01, first: 1'b1};
    vecs[5] = '{mask: 2'b10, r0: 1'b1, d0: 8'h00, r1: 1'b0, d1: 8'h02, first: 1'b1};

    do_reset(3);
    check_init("boot");

    for (int i = 0; i < 6; i++) run_round(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 10; i++) begin
      rv.mask = 2'($urandom_range(1, 3));
      rv.r0 = 1'($urandom_range(0, 1));
      rv.r1 = 1'($urandom_range(0, 1));
      rv.d0 = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'($urandom);
      rv.d1 = ($urandom_range(0, 3) == 0) ? 8'h02 : 8'($urandom);
      rv.first = (rv.mask == 2'b11) ? ptr_m : rv.mask[1];
      run_round(rv, $sformatf("rnd%0d", i));
    end

    // Request raised during power-up is held until init completes.
    @(negedge clk);
    do_reset(2);
    repeat (10) @(negedge clk);
    rs0 = 1'b1; data0 = 8'h5A; req = 2'b01;
    a0 = ack_count;
    check_init("initreq");
    n = 0;
    while (ack == 2'b00 && n < 300) begin @(negedge clk); n++; end
    chk("initreq_ack", int'(ack), 1);
    req = 2'b00;
    repeat (60) @(negedge clk);
    chk("initreq_ack_once", ack_count - a0, 1);
    chk("initreq_pulses", pulses.size(), 5);
    if (pulses.size() == 5) chk("initreq_bus", int'({pulses[4].rs, pulses[4].data}), int'({1'b1, 8'h5A}));

    // Reset in the middle of a client E pulse.
    n = 0;
    while ((busy || ack != 2'b00) && n < 3000) begin @(negedge clk); n++; end
    rs1 = 1'b1; data1 = 8'h77; req = 2'b10;
    n = 0;
    while (!LCD_E && n < 100) begin @(negedge clk); n++; end
    chk("ehigh_reached", int'(LCD_E), 1);
    a0 = ack_count;
    rel = cyc;
    do_reset(1);
    chk("abort_one_edge", cyc - rel, 1);
    check_init("replay");
    chk("abort_no_ack", ack_count - a0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/textlcd_bus_sched.md
Name: textlcd_bus_sched

Overview:
- Sequencer and arbiter for the shared 8-bit character LCD bus (HD44780-style: E, RS, RW, DATA[7:0]).
- After reset it runs the power-up delay and init command sequence.
- It then round-robin arbitrates two clients that each request a single command or character write.
- It generates a timed E strobe with setup, high, hold and post-write busy wait, replacing the free-running clk-as-E scheme.

Parameters:
- PWRUP_CYC, 100, idle cycles after reset before the first init command.
- SETUP_CYC, 2, cycles RS/RW/DATA are stable with E low before E rises.
- E_HIGH_CYC, 4, cycles E is held high.
- HOLD_CYC, 2, cycles bus is held after E falls.
- CMD_WAIT, 40, post-write wait cycles for normal commands and data.
- CLR_WAIT, 200, post-write wait cycles for clear (0x01) and home (0x02).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- req  in  2  per-client request, level, held until ack
- rs0  in  1  client 0 register select (0 = command, 1 = data)
- data0  in  8  client 0 byte
- rs1  in  1  client 1 register select
- data1  in  8  client 1 byte
- ack  out  2  one-cycle pulse: client's write fully completed
- busy  out  1  high whenever the FSM is not in IDLE
- init_done  out  1  high once the init sequence has finished; sticky until reset
- LCD_E  out  1  enable strobe
- LCD_RS  out  1  register select
- LCD_RW  out  1  read/write; always 0
- LCD_DATA  out  8  data bus

Behaviour:
- Reset: resetn is sampled low on a clk edge.
  - Outputs go to LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, ack=00, busy=1, init_done=0.
  - RR pointer resets to 0 (client 0 preferred). State goes to PWRUP. Counter clears.
  - Reset mid-transaction aborts immediately; no ack is issued; the full init sequence reruns.
- All outputs are registered. A single 16-bit cycle counter is shared by all timed states.
- FSM states: PWRUP, SETUP, EHIGH, HOLD, WAIT, IDLE.
- PWRUP: lasts PWRUP_CYC cycles, then loads init command 0 and enters SETUP.
- Init commands, all with RS=0, in order:
  - 0x38 (function set)
  - 0x0C (display on)
  - 0x06 (entry mode)
  - 0x01 (clear)
- SETUP: drives LCD_RS/LCD_DATA from the latched source, E=0, for SETUP_CYC cycles, then goes to EHIGH.
- EHIGH: E=1 for E_HIGH_CYC cycles, then goes to HOLD.
- HOLD: E=0, bus unchanged, for HOLD_CYC cycles, then goes to WAIT.
- WAIT: bus unchanged for CLR_WAIT cycles if latched RS=0 and DATA is 0x01 or 0x02; otherwise CMD_WAIT cycles.
- End of WAIT:
  - During init: advance to the next init command (back to SETUP). After the 4th, set init_done=1 and enter IDLE.
  - During a client write: pulse ack[g]=1 for exactly one cycle, coincident with the first IDLE cycle.
- IDLE:
  - busy=0.
  - Arbitration is skipped in any cycle where ack is high, which guarantees at least one idle cycle between grants.
  - Otherwise, if req != 0, grant per round-robin: the preferred client wins ties; a lone requester wins regardless.
  - On grant: latch rs/data of the winner, set preferred = the other client, enter SETUP next cycle.
- Requests asserted before init_done are held pending and are not granted until IDLE.
- A client must drop req in the cycle ack is seen. A req still high after the skip cycle is a new transaction.
- req dropped before grant is simply ignored. Input rs/data are only sampled at the grant edge.
- Latency from grant edge to ack: SETUP_CYC+E_HIGH_CYC+HOLD_CYC+wait+1 cycles.
- Counter is 16 bits. Parameters must be at least 1 and at most 65535; no wrap is expected.

Decomposition:
- Package textlcd_pkg holds:
  - FSM state encoding.
  - Init command constants CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_HOME=0x02.
  - INIT_LEN=4.
- One sub-module, rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], enable, pointer.
  - Outputs: one-hot grant, next pointer.
- Everything else lives in the top FSM.

Test Plan:
- Release reset, no requests:
  - After 100 idle cycles, exactly 4 E pulses, each 4 cycles high, carrying 0x38, 0x0C, 0x06, 0x01 with RS=0.
  - Gap after 0x01 uses the 200-cycle wait; then init_done=1 and busy=0.
- After init, req=01, rs0=1, data0=0x41:
  - One E pulse with RS=1, DATA=0x41, RW=0.
  - ack=01 pulses exactly 49 cycles after the grant edge.
- req=11 held continuously, each client dropping on its own ack:
  - Grants in order client0 then client1; each ack is a single cycle.
  - Repeat req=11: order is 0 then 1 again, since the pointer returns to 0 after client1 is granted.
- Client 1 sends rs1=0, data1=0x01:
  - Post-write wait is 200 cycles; ack at 209 cycles after grant.
  - Client 0 request raised meanwhile is granted only after the skip cycle.
- req=01 asserted 10 cycles after reset release:
  - No E pulse for the client until all 4 init pulses complete.
  - Client write follows init; ack is issued once.
- resetn low during EHIGH of a client write:
  - Next edge gives LCD_E=0, ack=00, busy=1, init_done=0.
  - After release, the full init sequence replays.
